// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared state encoding, byte-lane layout and default depth for
//            the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int c_lanes         = 4;
    localparam int c_lane_w        = $clog2(c_lanes);
    localparam int c_default_depth = 4096;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Big-endian: lane 0 lands in [31:24], lane 3 in [7:0].
    function automatic logic [4:0] lane_lsb(input logic [c_lane_w-1:0] lane);
        return {~lane, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Packs bytes big-endian into 32-bit words; a flush request emits
//            a pending partial word with the unfilled low lanes zeroed.
// Revision : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [7:0]          i_byte,
    input  logic                i_flush,
    output logic                o_word_ready,
    output logic [31:0]         o_word,
    output logic [c_lane_w-1:0] o_lane
);

    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);

    logic [c_lane_w-1:0] r_lane;
    logic [31:0]         r_shift;
    logic [31:0]         w_placed;

    // Lanes not yet written stay zero, which gives the flush padding for free.
    always_comb begin
        w_placed = r_shift;
        if (i_push) begin
            w_placed = r_shift | ({24'd0, i_byte} << lane_lsb(r_lane));
        end
    end

    assign o_word       = w_placed;
    assign o_lane       = r_lane;
    assign o_word_ready = (i_push && (r_lane == c_last_lane)) ||
                          (i_flush && (r_lane != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (o_word_ready) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_push) begin
            r_lane  <= r_lane + 1'b1;
            r_shift <= w_placed;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Fills instruction memory from a byte stream after reset and holds
//            the core halted until the program is written.
//            Optional checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = c_default_depth,
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             core_halt,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic             err_overflow,
    output logic             err_csum
);

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);

    state_t              r_state;
    logic                w_accept;
    logic                w_full;
    logic                w_is_csum;
    logic                w_push;
    logic                w_flush;
    logic                w_word_ready;
    logic [31:0]         w_word;
    logic [c_lane_w-1:0] w_lane;
    logic                w_pending_after;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_is_csum = in_last;
`else
    assign w_is_csum = 1'b0;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_full   = (word_count == c_depth);
    assign w_push   = w_accept && !w_full && !w_is_csum;
    assign w_flush  = (r_state == FLUSH);

    // After the final byte, a partial word still in the assembler needs FLUSH.
    assign w_pending_after = w_push ? (w_lane != c_last_lane) : (w_lane != '0);

    word_assembler u_word_assembler (
        .clk          (clk),
        .rst          (rs),
        .i_push       (w_push),
        .i_byte       (in_data),
        .i_flush      (w_flush),
        .o_word_ready (w_word_ready),
        .o_word       (w_word),
        .o_lane       (w_lane)
    );

    always_ff @(posedge clk) begin
        if (rs) begin
            r_state      <= LOAD;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            core_halt    <= 1'b1;
            done         <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (w_word_ready) begin
                wr_en      <= 1'b1;
                wr_addr    <= 32'(word_count);
                wr_data    <= w_word;
                word_count <= word_count + 1'b1;
            end
            if (w_accept && w_full) begin
                err_overflow <= 1'b1;
            end
            // Status trails the state so it rises the cycle after the last write.
            done      <= (r_state == DONE);
            core_halt <= (r_state != DONE);
            case (r_state)
                LOAD: begin
                    if (w_accept && in_last) begin
                        in_ready <= 1'b0;
                        r_state  <= w_pending_after ? FLUSH : DONE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    in_ready <= 1'b0;
                    r_state  <= DONE;
                end
                default: begin
                    in_ready <= 1'b0;
                    r_state  <= DONE;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_csum_bad;

    // Discarded overflow bytes still count toward the checksum.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_xor      <= '0;
            r_csum_bad <= 1'b0;
            err_csum   <= 1'b0;
        end else begin
            if (w_accept && !in_last) begin
                r_xor <= r_xor ^ in_data;
            end
            if (w_accept && in_last) begin
                r_csum_bad <= (in_data != r_xor);
            end
            err_csum <= r_csum_bad && (r_state == DONE);
        end
    end
`else
    assign err_csum = 1'b0;
`endif

endmodule
`default_nettype wire
